// File: rtl/log_reader.sv
// -----------------------------------------------------------------------------
// log_reader
//
// Dumps the contents of a captured log memory to a microcontroller, one word
// at a time, over a valid/ready handshake.
//
// A dump starts on a rising edge of i_start while idle. If the log memory
// holds a complete capture (i_mem_full), every address from 0 up to
// 2**ADDR_W-1 is read in order, and each word is presented on o_data until
// the micro accepts it. If the memory is not full, the request is refused
// with a one-cycle o_err pulse. A dump can be cut short at any time with
// i_abort.
//
// Per-word sequence (three cycles minimum):
//   ISSUE : o_mem_en high for one cycle, o_mem_addr = word index
//   WAIT  : memory returns data; it is captured into o_data on the next edge
//   HOLD  : o_valid high, o_data stable until i_ready is seen
//
// Ports
//   clock       : single clock for all logic
//   i_reset     : synchronous, active-low reset
//   i_mem_full  : log memory holds a complete capture
//   i_start     : dump request (level; only its rising edge matters)
//   i_abort     : abort a running dump, back to idle without o_done
//   o_mem_en    : log memory read enable
//   o_mem_addr  : log memory read address (always the word counter)
//   i_mem_data  : log memory read data, valid one cycle after o_mem_en
//   o_data      : word presented to the micro
//   o_valid     : o_data is valid
//   i_ready     : micro accepts o_data
//   o_busy      : a dump is in progress (any state other than idle)
//   o_done      : one-cycle pulse after the last word is accepted
//   o_err       : one-cycle pulse when a start request is refused
// -----------------------------------------------------------------------------
module log_reader #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic              i_mem_full,
   input  logic              i_start,
   input  logic              i_abort,
   output logic              o_mem_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [DATA_W-1:0] i_mem_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   state_t            state_r;
   logic [ADDR_W-1:0] count_r;
   logic              start_r;
   logic              start_seen_low_r;
   logic              trigger_s;
   logic              transfer_s;
   logic              last_word_s;

   // The counter register drives the memory address directly, so the address
   // is registered and holds the counter in every state.
   assign o_mem_addr = count_r;

   // Decode the start trigger, the handshake and the last-address condition.
   always_comb begin
      // start_seen_low_r keeps a level that was already high when reset
      // released from looking like a fresh rising edge: i_start must first
      // be observed low after reset.
      trigger_s   = start_seen_low_r & i_start & ~start_r;
      // o_valid is only ever high in HOLD, so this is the HOLD transfer.
      transfer_s  = o_valid & i_ready;
      last_word_s = (count_r == ADDR_LAST);
   end

   // Registered copy of i_start for edge detection, plus the post-reset arm.
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         start_r          <= 1'b0;
         start_seen_low_r <= 1'b0;
      end else begin
         start_r          <= i_start;
         start_seen_low_r <= start_seen_low_r | ~i_start;
      end
   end

   // Dump sequencer: read issue, data capture, handshake, completion, abort.
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         state_r  <= ST_IDLE;
         count_r  <= ADDR_ZERO;
         o_mem_en <= 1'b0;
         o_data   <= DATA_ZERO;
         o_valid  <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         // Pulse outputs default low; they are raised only on the edge that
         // enters the state in which they must be seen.
         o_mem_en <= 1'b0;
         o_done   <= 1'b0;
         o_err    <= 1'b0;

         if (i_abort && (state_r != ST_IDLE)) begin
            // Abort wins over everything, including a transfer on the same
            // edge; the pending word is dropped and no o_done is produced.
            state_r <= ST_IDLE;
            count_r <= ADDR_ZERO;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (trigger_s) begin
                     if (i_mem_full) begin
                        state_r  <= ST_ISSUE;
                        count_r  <= ADDR_ZERO;
                        o_mem_en <= 1'b1;
                        o_busy   <= 1'b1;
                     end else begin
                        o_err    <= 1'b1;
                     end
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end

               ST_ISSUE: begin
                  // The read was presented during this cycle; the memory
                  // answers in the next one.
                  state_r <= ST_WAIT;
               end

               ST_WAIT: begin
                  o_data  <= i_mem_data;
                  o_valid <= 1'b1;
                  state_r <= ST_HOLD;
               end

               ST_HOLD: begin
                  if (transfer_s) begin
                     o_valid <= 1'b0;
                     if (last_word_s) begin
                        // Counter stays at the top address; it is cleared
                        // on the way back to idle, never wrapped.
                        state_r <= ST_DONE;
                        o_done  <= 1'b1;
                     end else begin
                        count_r  <= count_r + ADDR_ONE;
                        state_r  <= ST_ISSUE;
                        o_mem_en <= 1'b1;
                     end
                  end else begin
                     state_r <= ST_HOLD;
                  end
               end

               ST_DONE: begin
                  state_r <= ST_IDLE;
                  count_r <= ADDR_ZERO;
                  o_busy  <= 1'b0;
               end

               default: begin
                  state_r  <= ST_IDLE;
                  count_r  <= ADDR_ZERO;
                  o_mem_en <= 1'b0;
                  o_valid  <= 1'b0;
                  o_busy   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/log_reader.md
LOG_READER -- requirements
Module: log_reader

Interface
REQ-001 Parameter ADDR_W, default 15, log memory address width; depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, log memory word width.
REQ-003 clock  input  1  single clock for all logic.
REQ-004 i_reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clock.
REQ-005 i_mem_full  input  1  high when the log memory holds a complete capture.
REQ-006 i_start  input  1  dump request from the micro; level signal, may stay high for many cycles.
REQ-007 i_abort  input  1  aborts a running dump.
REQ-008 o_mem_en  output  1  log memory read enable.
REQ-009 o_mem_addr  output  ADDR_W  log memory read address.
REQ-010 i_mem_data  input  DATA_W  log memory read data, valid exactly 1 cycle after o_mem_en is high.
REQ-011 o_data  output  DATA_W  word presented to the micro.
REQ-012 o_valid  output  1  o_data is valid.
REQ-013 i_ready  input  1  micro accepts o_data.
REQ-014 o_busy  output  1  high in any state other than IDLE.
REQ-015 o_done  output  1  one-cycle pulse after the last word is accepted.
REQ-016 o_err  output  1  one-cycle pulse when a start request is rejected.

Function
REQ-017 The start trigger is the rising edge of i_start, detected against a registered copy of i_start; a held-high level produces only one trigger.
REQ-018 FSM states are IDLE, ISSUE, WAIT, HOLD and DONE.
REQ-019 IDLE: on a start trigger with i_mem_full=1, clear the address counter to 0 and go to ISSUE.
REQ-020 IDLE: on a start trigger with i_mem_full=0, pulse o_err for 1 cycle and remain in IDLE.
REQ-021 ISSUE: drive o_mem_en=1 and o_mem_addr equal to the counter for exactly 1 cycle, then go to WAIT.
REQ-022 WAIT: register i_mem_data into o_data, set o_valid=1 on the next edge, and go to HOLD.
REQ-023 o_mem_en is 0 in every state except ISSUE.
REQ-024 o_mem_addr holds the counter value in all states.
REQ-025 HOLD: o_data and o_valid stay stable until a cycle with o_valid=1 and i_ready=1 (a transfer).
REQ-026 On a transfer, o_valid is cleared on the same edge.
REQ-027 On a transfer with counter below 2**ADDR_W-1, increment the counter and go to ISSUE.
REQ-028 On a transfer with counter equal to 2**ADDR_W-1, go to DONE; the counter does not wrap.
REQ-029 Throughput is at most one word per 3 cycles; the first o_valid is asserted 3 cycles after the trigger edge.
REQ-030 DONE: o_done=1 for exactly 1 cycle, then return to IDLE; the counter is cleared to 0.
REQ-031 i_abort=1 in any non-IDLE state: go to IDLE on the next edge, clear o_valid and the counter, and do not pulse o_done.
REQ-032 i_abort has priority over a simultaneous transfer.
REQ-033 i_abort in IDLE has no effect.
REQ-034 Start triggers outside IDLE are ignored and do not pulse o_err.
REQ-035 i_mem_full falling during a dump does not stop the dump.
REQ-036 i_ready while o_valid=0 has no effect.

Reset
REQ-037 i_reset=0 at a clock edge forces IDLE, counter=0, o_mem_addr=0, o_mem_en=0, o_data=0, o_valid=0, o_busy=0, o_done=0, o_err=0, and clears the registered i_start.
REQ-038 A reset asserted mid-dump takes effect at the next edge with the same values as REQ-037; no o_done pulse follows.
REQ-039 After reset release, a trigger requires i_start to go 0 then 1, i.e. a level held high across reset is not a trigger.

Verification (bench ADDR_W=3, DATA_W=8, memory word n = 8'hA0+n)
REQ-040 Full dump, i_mem_full=1, start pulse, i_ready=1 -> o_data sequence A0..A7 with o_valid each time, o_mem_addr 0..7, o_done pulses once, o_busy returns to 0.
REQ-041 Backpressure: i_ready=0 for 5 cycles on word 3 -> o_data=A3 held stable with o_valid=1, no o_mem_en pulse until accepted, sequence unchanged.
REQ-042 Start with i_mem_full=0 -> o_err pulses 1 cycle, o_busy stays 0, o_mem_en never asserts.
REQ-043 i_abort after word 2 is accepted -> IDLE next cycle, o_valid=0, no o_done; a new start then restarts at A0.
REQ-044 i_start held high for 40 cycles -> exactly one dump of 8 words; re-pulsing i_start after o_done -> second identical dump.
REQ-045 i_reset=0 while in HOLD at word 5 -> all outputs at reset values next edge; no o_done pulse.
